// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Multiply is shift-add, divide is restoring; both take WIDTH iterations
// followed by one sign-fix edge that writes hi/lo and pulses done.
// Optional build macro MULDIV_FAST_MULT_EN: mult/multu finish in one CALC
// cycle using the native multiplier; divide timing is unchanged.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CntInit = CW'(WIDTH);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   rs_q;       // raw dividend, returned on divide by zero
    logic               neg_q;      // operand signs differ (signed ops only)
    logic               sgn_a_q;    // dividend negative (signed ops only)
    logic               dz_q;       // divisor was zero
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept;
    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     div_rem, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // A start is taken only from IDLE and never alongside a flush.
    assign accept    = (state_q == StIdle) && start && !flush;
    assign is_signed = ~op[0];
    assign a_neg     = is_signed & rs_data[WIDTH-1];
    assign b_neg     = is_signed & rt_data[WIDTH-1];
    assign mag_a     = a_neg ? -rs_data : rs_data;
    assign mag_b     = b_neg ? -rt_data : rt_data;

    // State and iteration counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: flush cancels anything in flight.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCalc;
                    cnt_d   = CntInit;
                end
            end
            StCalc: begin
                cnt_d = cnt_q - CntOne;
                if (flush) begin
                    state_d = StIdle;
`ifdef MULDIV_FAST_MULT_EN
                end else if (!op_q[1] || cnt_q == CntOne) begin
`else
                end else if (cnt_q == CntOne) begin
`endif
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs and HI/LO next values: FIX writes results, idle moves write rs_data.
    always_comb begin
        busy   = (state_q != StIdle);
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (state_q == StFix && !flush) begin
            done_d = 1'b1;
            if (!op_q[1]) begin
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
            end else if (dz_q) begin
                hi_d = rs_q;
                lo_d = '1;
            end else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end else if (state_q == StIdle && !accept) begin
            if (mthi) hi_d = rs_data;
            if (mtlo) lo_d = rs_data;
        end
    end

    // One iteration of the datapath; accumulator is {high/remainder, low/quotient}.
    always_comb begin
        div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_rem - {1'b0, opb_q};
        if (op_q[1]) begin
            if (!div_diff[WIDTH]) begin
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
`ifdef MULDIV_FAST_MULT_EN
            acc_d = {{WIDTH{1'b0}}, opb_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
            // Add multiplicand into the upper half when the low bit is set, then shift.
            acc_d = {({1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}})),
                     acc_q[WIDTH-1:1]};
`endif
        end
    end

    // Sign correction applied on the FIX edge.
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = sgn_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Operand capture on accepted start and accumulator update during CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            opb_q   <= '0;
            rs_q    <= '0;
            neg_q   <= 1'b0;
            sgn_a_q <= 1'b0;
            dz_q    <= 1'b0;
            acc_q   <= '0;
        end else if (accept) begin
            op_q    <= op;
            opb_q   <= mag_b;
            rs_q    <= rs_data;
            neg_q   <= a_neg ^ b_neg;
            sgn_a_q <= a_neg;
            dz_q    <= (rt_data == '0);
            acc_q   <= {{WIDTH{1'b0}}, mag_a};
        end else if (state_q == StCalc) begin
            acc_q   <= acc_d;
        end
    end

    // Architectural HI/LO and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned WIDTH = 32;
    localparam int DivLat = WIDTH + 1;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MulLat = 2;
`else
    localparam int MulLat = WIDTH + 1;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             flush;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .flush   (flush),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: returns {hi, lo} using ordinary signed/unsigned arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == 32'h0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else res = {(ua % ub) & 64'hFFFF_FFFF, (ua / ub) & 64'hFFFF_FFFF} >> 0;
            end
        endcase
        if (o == 2'b11 && b != 32'h0) res = {32'((ua % ub)), 32'((ua / ub))};
        return res;
    endfunction

    // Issue one operation and check latency, busy, results and the single done pulse.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic with_move);
        logic [63:0] expv;
        int got;
        logic busy_drop;
        expv = model(o, a, b);
        @(negedge clk);
        start = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
        mthi = with_move;
        mtlo = with_move;
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        chk({tag, "_busy_start"}, 64'(busy), 64'(1));
        got = 0;
        busy_drop = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = k;
                break;
            end
            if (!busy) busy_drop = 1'b1;
        end
        chk({tag, "_latency"}, 64'(got), 64'(o[1] ? DivLat : MulLat));
        chk({tag, "_busy_hold"}, 64'(busy_drop), 64'(0));
        chk({tag, "_hi"}, 64'(hi), 64'(expv[63:32]));
        chk({tag, "_lo"}, 64'(lo), 64'(expv[31:0]));
        chk({tag, "_busy_end"}, 64'(busy), 64'(0));
        exp_hi = expv[63:32];
        exp_lo = expv[31:0];
        @(posedge clk);
        #1;
        chk({tag, "_done_once"}, 64'(done), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op = 2'b00;
        rs_data = '0;
        rt_data = '0;
        flush = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        #12;
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the corner-case list.
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max_hi_abs", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        chk("multu_max_lo_abs", 64'(lo), 64'h0000_0000_0000_0001);
        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        chk("mult_neg3x7_lo_abs", 64'(lo), 64'h0000_0000_FFFF_FFEB);
        run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("mult_min_sq_hi_abs", 64'(hi), 64'h0000_0000_4000_0000);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        chk("div_neg7_2_lo_abs", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_neg7_2_hi_abs", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        run_op("divu_7_2", 2'b11, 32'h0000_0007, 32'h0000_0002, 1'b0);
        run_op("div_by0", 2'b10, 32'h1234_5678, 32'h0000_0000, 1'b0);
        chk("div_by0_hi_abs", 64'(hi), 64'h0000_0000_1234_5678);
        run_op("divu_by0", 2'b11, 32'h8765_4321, 32'h0000_0000, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo_abs", 64'(lo), 64'h0000_0000_8000_0000);
        run_op("start_wins", 2'b01, 32'h0000_1234, 32'h0000_0100, 1'b1);

        // Moves in IDLE, both together.
        @(negedge clk);
        rs_data = 32'h1357_9BDF;
        mthi = 1'b1;
        mtlo = 1'b1;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        exp_hi = 32'h1357_9BDF;
        exp_lo = 32'h1357_9BDF;
        chk("mt_both_hi", 64'(hi), 64'(exp_hi));
        chk("mt_both_lo", 64'(lo), 64'(exp_lo));

        // start, mthi ignored while busy; flush cancels without a result.
        begin
            logic seen_done;
            logic busy_drop;
            seen_done = 1'b0;
            busy_drop = 1'b0;
            @(negedge clk);
            start = 1'b1;
            op = 2'b11;
            rs_data = 32'h0000_0064;
            rt_data = 32'h0000_0003;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                start = (c == 5);
                op = (c == 5) ? 2'b01 : 2'b11;
                mthi = (c == 8);
                flush = (c == 10);
                rs_data = (c == 8) ? 32'hDEAD_BEEF : 32'h0000_0005;
                @(posedge clk);
                #1;
                if (done) seen_done = 1'b1;
                if (c < 10 && !busy) busy_drop = 1'b1;
            end
            start = 1'b0;
            mthi = 1'b0;
            flush = 1'b0;
            chk("flush_busy_hold", 64'(busy_drop), 64'(0));
            chk("flush_busy_off", 64'(busy), 64'(0));
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                if (done) seen_done = 1'b1;
            end
            chk("flush_no_done", 64'(seen_done), 64'(0));
            chk("flush_hi_kept", 64'(hi), 64'(exp_hi));
            chk("flush_lo_kept", 64'(lo), 64'(exp_lo));
        end
        run_op("after_flush", 2'b10, 32'hFFFF_FF9C, 32'h0000_0007, 1'b0);

        // Random operations.
        for (int i = 0; i < 24; i++) begin
            logic [1:0] ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) rb = 32'h0;
            else if (i % 4 == 1) rb = $urandom_range(1, 15);
            else if (i % 4 == 2) rb = -$urandom_range(1, 15);
            run_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
        end

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1;
        op = 2'b10;
        rs_data = 32'h7654_3210;
        rt_data = 32'h0000_0013;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hi", 64'(hi), 64'(0));
        chk("arst_lo", 64'(lo), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rs_data = 32'hA5A5_A5A5;
        mthi = 1'b1;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        chk("post_rst_mthi_hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
        chk("post_rst_mthi_lo", 64'(lo), 64'(0));
        chk("post_rst_busy", 64'(busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
